// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter and frame sequencer sharing one UART TX
// among NUM_REQ requesters. One byte is accepted at a time. It is launched with
// a single-cycle tx_data_valid, and the grant is held until tx_busy falls.
//
// Ports:
//   CLK, RST        clock (rising edge), synchronous active-high reset
//   req_valid       per-requester frame pending
//   req_data        packed payloads, requester i at [i*DATA_SIZE +: DATA_SIZE]
//   req_par_en      per-requester parity enable
//   req_par_typ     per-requester parity type (0 even, 1 odd)
//   req_ready       one-hot, one-cycle accept pulse
//   tx_busy         Busy from the UART TX
//   tx_p_data       payload to the UART TX (stable from launch to next launch)
//   tx_data_valid   single-cycle launch strobe to the UART TX
//   tx_par_en       parity enable to the UART TX
//   tx_par_typ      parity type to the UART TX
//   grant_id        index of the granted requester
//   grant_active    high from launch until the frame completes
//   err_timeout     one-cycle pulse when the UART TX never went busy
module uart_tx_arbiter #(
    parameter int unsigned DATA_SIZE    = 8,
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned ID_W         = 2,
    parameter int unsigned BUSY_TIMEOUT = 15
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
    input  logic [NUM_REQ-1:0]           req_par_en,
    input  logic [NUM_REQ-1:0]           req_par_typ,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         tx_busy,
    output logic [DATA_SIZE-1:0]         tx_p_data,
    output logic                         tx_data_valid,
    output logic                         tx_par_en,
    output logic                         tx_par_typ,
    output logic [ID_W-1:0]              grant_id,
    output logic                         grant_active,
    output logic                         err_timeout
);

    localparam int unsigned CNT_RAW = $clog2(BUSY_TIMEOUT + 1);
    localparam int unsigned CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam int unsigned SUM_W   = ID_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUSY_TIMEOUT);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);
    localparam logic [SUM_W-1:0] NREQ_S  = SUM_W'(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [NUM_REQ-1:0]   req_ready_d;
    logic [DATA_SIZE-1:0] tx_p_data_d;
    logic                 tx_data_valid_d;
    logic                 tx_par_en_d;
    logic                 tx_par_typ_d;
    logic [ID_W-1:0]      grant_id_d;
    logic                 grant_active_d;
    logic                 err_timeout_d;

    logic [2*NUM_REQ-1:0] dbl_valid;
    logic [SUM_W-1:0]     win_sum;
    logic [SUM_W-1:0]     win_wrap;
    logic                 win_found;
    logic [ID_W-1:0]      win_id;
    logic [NUM_REQ-1:0]   win_oh;
    logic [DATA_SIZE-1:0] win_data;
    logic                 win_par_en;
    logic                 win_par_typ;
    logic [ID_W-1:0]      next_ptr;

    // Rotating priority search: rotate requests so rr_ptr sits at bit 0, take
    // the lowest set bit, then map the offset back to a requester index.
    always_comb begin
        dbl_valid = {req_valid, req_valid} >> rr_ptr_q;
        win_found = 1'b0;
        win_sum   = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            if (dbl_valid[k]) begin
                win_found = 1'b1;
                win_sum   = {1'b0, rr_ptr_q} + SUM_W'(k);
            end
        end
        win_wrap = (win_sum >= NREQ_S) ? (win_sum - NREQ_S) : win_sum;
        win_id   = win_wrap[ID_W-1:0];
    end

    // Winner payload mux and one-hot accept vector.
    always_comb begin
        win_oh      = '0;
        win_data    = '0;
        win_par_en  = 1'b0;
        win_par_typ = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (win_id == ID_W'(i)) begin
                win_oh[i]   = 1'b1;
                win_data    = req_data[i*DATA_SIZE +: DATA_SIZE];
                win_par_en  = req_par_en[i];
                win_par_typ = req_par_typ[i];
            end
        end
    end

    // The just-served requester drops to lowest priority.
    assign next_ptr = (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);

    // Next-state and next-output logic.
    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        cnt_d           = cnt_q;
        req_ready_d     = '0;
        tx_data_valid_d = 1'b0;
        err_timeout_d   = 1'b0;
        tx_p_data_d     = tx_p_data;
        tx_par_en_d     = tx_par_en;
        tx_par_typ_d    = tx_par_typ;
        grant_id_d      = grant_id;
        grant_active_d  = grant_active;

        unique case (state_q)
            IDLE: begin
                // Outputs are registered, so the launch strobe and accept
                // pulse are loaded here and appear during the LAUNCH cycle.
                if (!tx_busy && win_found) begin
                    tx_p_data_d     = win_data;
                    tx_par_en_d     = win_par_en;
                    tx_par_typ_d    = win_par_typ;
                    grant_id_d      = win_id;
                    req_ready_d     = win_oh;
                    tx_data_valid_d = 1'b1;
                    grant_active_d  = 1'b1;
                    state_d         = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_MAX) begin
                        err_timeout_d  = 1'b1;
                        rr_ptr_d       = next_ptr;
                        grant_active_d = 1'b0;
                        state_d        = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    rr_ptr_d       = next_ptr;
                    grant_active_d = 1'b0;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            cnt_q         <= '0;
            req_ready     <= '0;
            tx_p_data     <= '0;
            tx_data_valid <= 1'b0;
            tx_par_en     <= 1'b0;
            tx_par_typ    <= 1'b0;
            grant_id      <= '0;
            grant_active  <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            cnt_q         <= cnt_d;
            req_ready     <= req_ready_d;
            tx_p_data     <= tx_p_data_d;
            tx_data_valid <= tx_data_valid_d;
            tx_par_en     <= tx_par_en_d;
            tx_par_typ    <= tx_par_typ_d;
            grant_id      <= grant_id_d;
            grant_active  <= grant_active_d;
            err_timeout   <= err_timeout_d;
        end
    end

endmodule
